// File: rtl/lfsr_pkg.sv
// Shared constants, FSM state type and LFSR step function for the message decrypt engine.
package lfsr_pkg;

    localparam int unsigned AW       = 8;
    localparam int unsigned SRC_BASE = 64;
    localparam int unsigned DST_BASE = 0;
    localparam int unsigned MSG_LEN  = 64;
    localparam int unsigned PRE_MIN  = 10;
    localparam int unsigned N_PTRN   = 9;

    localparam logic [6:0] LFSR_PTRN [N_PTRN] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEARCH,
        ST_DECRYPT,
        ST_DONE
    } state_t;

    // Shift left, feedback is the parity of the tapped bits.
    function automatic logic [6:0] lfsr_next(input logic [6:0] s, input logic [6:0] taps);
        return {s[5:0], ^(s & taps)};
    endfunction

endpackage

// File: rtl/lfsr_msg_decoder_if.sv
// Start/complete handshake plus shared data-memory port of the decrypt engine.
interface lfsr_msg_decoder_if;
    import lfsr_pkg::*;

    logic          req;
    logic          ack;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          pat_err;
    logic [3:0]    pat_idx;

    modport master (
        input  req, rd_data,
        output ack, rd_addr, wr_en, wr_addr, wr_data, pat_err, pat_idx
    );

    modport slave (
        output req, rd_data,
        input  ack, rd_addr, wr_en, wr_addr, wr_data, pat_err, pat_idx
    );

endinterface

// File: rtl/lfsr7.sv
// Loadable 7-bit Fibonacci-style LFSR; load has priority over step.
module lfsr7
    import lfsr_pkg::*;
(
    input  logic       clk,
    input  logic       init_n,
    input  logic       load,
    input  logic       step,
    input  logic [6:0] taps,
    input  logic [6:0] seed,
    output logic [6:0] q
);

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n)   q <= '0;
        else if (load) q <= seed;
        else if (step) q <= lfsr_next(q, taps);
    end

endmodule

// File: rtl/lfsr_msg_decoder.sv
// Recovers LFSR taps/seed from the space preamble, decrypts the stream and strips leading spaces.
// Build option: define PARITY_FLAG_EN to flag parity-corrupt bytes as 8'h80.
module lfsr_msg_decoder
    import lfsr_pkg::*;
(
    input  logic               clk,
    input  logic               init_n,
    lfsr_msg_decoder_if.master bus
);

`ifdef PARITY_FLAG_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int unsigned CW = $clog2(MSG_LEN + 2);

    state_t        state, state_d;
    logic          req_q;
    logic [CW-1:0] cnt, cnt_d;
    logic [3:0]    k, k_d;
    logic [AW-1:0] rd_addr, rd_addr_d;
    logic [AW-1:0] wr_addr, wr_addr_d;
    logic [AW-1:0] wr_ptr, wr_ptr_d;
    logic          wr_en, wr_en_d;
    logic [7:0]    wr_data, wr_data_d;
    logic          ack, ack_d;
    logic          pat_err, pat_err_d;
    logic [3:0]    pat_idx, pat_idx_d;
    logic [6:0]    taps_q, taps_d;
    logic          skip_q, skip_d;
    logic [6:0]    pbuf [PRE_MIN];
    logic [6:0]    lfsr_q;
    logic          cap_c, lfsr_load_c, lfsr_step_c, match_c, bad_c;
    logic [6:0]    cand_c, pt_c;

    assign cand_c = LFSR_PTRN[k];
    assign pt_c   = bus.rd_data[6:0] ^ lfsr_q;
    assign bad_c  = PARITY_EN & (^bus.rd_data);

    // Candidate taps must reproduce every preamble transition.
    always_comb begin
        match_c = 1'b1;
        for (int i = 0; i < int'(PRE_MIN) - 1; i++) begin
            if (pbuf[i+1] != lfsr_next(pbuf[i], cand_c)) match_c = 1'b0;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        k_d         = k;
        rd_addr_d   = rd_addr;
        wr_addr_d   = wr_addr;
        wr_ptr_d    = wr_ptr;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data;
        pat_err_d   = pat_err;
        pat_idx_d   = pat_idx;
        taps_d      = taps_q;
        skip_d      = skip_q;
        cap_c       = 1'b0;
        lfsr_load_c = 1'b0;
        lfsr_step_c = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (req_q && !bus.req) begin
                    state_d   = ST_LOAD;
                    cnt_d     = '0;
                    rd_addr_d = AW'(SRC_BASE);
                    wr_ptr_d  = AW'(DST_BASE);
                    pat_err_d = 1'b0;
                    pat_idx_d = '0;
                end
            end
            // Read data lags the address by one cycle, so capture starts at cnt=1.
            ST_LOAD: begin
                rd_addr_d = rd_addr + AW'(1);
                cnt_d     = cnt + CW'(1);
                cap_c     = (cnt != '0);
                if (cnt == CW'(PRE_MIN)) begin
                    state_d = ST_SEARCH;
                    k_d     = '0;
                end
            end
            ST_SEARCH: begin
                if (match_c) begin
                    state_d     = ST_DECRYPT;
                    taps_d      = cand_c;
                    pat_idx_d   = k;
                    lfsr_load_c = 1'b1;
                    cnt_d       = '0;
                    rd_addr_d   = AW'(SRC_BASE);
                    skip_d      = 1'b1;
                end else if (k == 4'(N_PTRN - 1)) begin
                    pat_err_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    k_d = k + 4'd1;
                end
            end
            // Cycle cnt handles byte cnt-1; one spare cycle lets the last write retire before ack.
            ST_DECRYPT: begin
                cnt_d = cnt + CW'(1);
                if (cnt < CW'(MSG_LEN - 1)) rd_addr_d = rd_addr + AW'(1);
                if (cnt != '0 && cnt <= CW'(MSG_LEN)) begin
                    lfsr_step_c = 1'b1;
                    if (!(skip_q && !bad_c && pt_c == 7'd0)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = wr_ptr;
                        wr_ptr_d  = wr_ptr + AW'(1);
                        wr_data_d = bad_c ? 8'h80 : {1'b0, pt_c};
                        skip_d    = 1'b0;
                    end
                end
                if (cnt == CW'(MSG_LEN + 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.req) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ack_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state   <= ST_IDLE;
            req_q   <= 1'b0;
            cnt     <= '0;
            k       <= '0;
            rd_addr <= AW'(SRC_BASE);
            wr_addr <= AW'(DST_BASE);
            wr_ptr  <= AW'(DST_BASE);
            wr_en   <= 1'b0;
            wr_data <= '0;
            ack     <= 1'b0;
            pat_err <= 1'b0;
            pat_idx <= '0;
            taps_q  <= '0;
            skip_q  <= 1'b0;
        end else begin
            state   <= state_d;
            req_q   <= bus.req;
            cnt     <= cnt_d;
            k       <= k_d;
            rd_addr <= rd_addr_d;
            wr_addr <= wr_addr_d;
            wr_ptr  <= wr_ptr_d;
            wr_en   <= wr_en_d;
            wr_data <= wr_data_d;
            ack     <= ack_d;
            pat_err <= pat_err_d;
            pat_idx <= pat_idx_d;
            taps_q  <= taps_d;
            skip_q  <= skip_d;
        end
    end

    // Preamble shift buffer: first byte read ends up in pbuf[0].
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            for (int i = 0; i < int'(PRE_MIN); i++) pbuf[i] <= '0;
        end else if (cap_c) begin
            for (int i = 0; i < int'(PRE_MIN) - 1; i++) pbuf[i] <= pbuf[i+1];
            pbuf[PRE_MIN-1] <= bus.rd_data[6:0];
        end
    end

    lfsr7 u_lfsr (
        .clk    (clk),
        .init_n (init_n),
        .load   (lfsr_load_c),
        .step   (lfsr_step_c),
        .taps   (taps_q),
        .seed   (pbuf[0]),
        .q      (lfsr_q)
    );

    assign bus.ack     = ack;
    assign bus.rd_addr = rd_addr;
    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;
    assign bus.pat_err = pat_err;
    assign bus.pat_idx = pat_idx;

endmodule

// File: tb/tb_lfsr_msg_decoder.sv
// Scoreboard bench for lfsr_msg_decoder: encrypts directed messages into a RAM model and checks every write.
module tb_lfsr_msg_decoder;
    import lfsr_pkg::*;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic init_n;
    logic clr_dst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   wr_seen  = 0;
    wr_t  sb [$];

    logic [7:0] src [MSG_LEN];
    logic [7:0] dst [256];

    always #5 clk = ~clk;

    lfsr_msg_decoder_if bus ();

    lfsr_msg_decoder dut (
        .clk    (clk),
        .init_n (init_n),
        .bus    (bus)
    );

    // Synchronous RAM: encrypted stream at 64..127, output region below.
    always @(posedge clk) begin
        if (clr_dst) begin
            for (int i = 0; i < 256; i++) dst[i] <= 8'hEE;
        end else if (bus.wr_en) begin
            dst[bus.wr_addr] <= bus.wr_data;
        end
        bus.rd_data <= (bus.rd_addr[7:6] == 2'b01) ? src[bus.rd_addr[5:0]] : dst[bus.rd_addr];
    end

    // Monitor: every write strobe pops one expected write.
    always @(negedge clk) begin
        wr_t e;
        if (init_n && bus.wr_en) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write actual addr=%0h data=%0h required=no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                e = sb.pop_front();
                if (bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
                    n_fail++;
                    $display("FAIL write_%0d actual addr=%0h data=%0h required addr=%0h data=%0h",
                             wr_seen, bus.wr_addr, bus.wr_data, e.addr, e.data);
                end
            end
            wr_seen++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Encrypt msg behind a pre-space preamble and queue the expected plaintext writes.
    task automatic stage(input logic [6:0] taps, input logic [6:0] init, input int pre,
                         input string msg, input int flip_idx, input int flip_bit);
        logic [6:0] s, p, c;
        logic [7:0] ch;
        logic [7:0] exp_b [MSG_LEN];
        int first;
        s = init;
        for (int i = 0; i < int'(MSG_LEN); i++) begin
            ch = 8'h20;
            if (i >= pre && (i - pre) < msg.len()) ch = msg[i - pre];
            p = 7'(ch - 8'h20);
            c = p ^ s;
            src[i]   = {^c, c};
            exp_b[i] = {1'b0, p};
            s = {s[5:0], ^(s & taps)};
        end
        if (flip_idx >= 0) begin
            src[flip_idx][flip_bit] = ~src[flip_idx][flip_bit];
`ifdef PARITY_FLAG_EN
            exp_b[flip_idx] = 8'h80;
`else
            if (flip_bit < 7) exp_b[flip_idx][flip_bit] = ~exp_b[flip_idx][flip_bit];
`endif
        end
        first = int'(MSG_LEN);
        for (int i = int'(MSG_LEN) - 1; i >= 0; i--) if (exp_b[i] != 8'h00) first = i;
        for (int i = first; i < int'(MSG_LEN); i++)
            sb.push_back('{addr: 8'(i - first), data: exp_b[i]});
    endtask

    task automatic launch();
        wr_seen = 0;
        clr_dst = 1'b1;
        bus.req = 1'b1;
        @(posedge clk);
        #1 clr_dst = 1'b0;
        @(posedge clk);
        #1 bus.req = 1'b0;
    endtask

    task automatic finish_run(input string tag, input logic exp_err, input logic [3:0] exp_idx,
                              input int exp_writes);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.ack && cyc < 300);
        check({tag, "_ack"}, 32'(bus.ack), 32'(1));
        check({tag, "_pat_err"}, 32'(bus.pat_err), 32'(exp_err));
        if (!exp_err) check({tag, "_pat_idx"}, 32'(bus.pat_idx), 32'(exp_idx));
        @(negedge clk);
        check({tag, "_pending"}, 32'(sb.size()), 32'(0));
        check({tag, "_writes"}, 32'(wr_seen), 32'(exp_writes));
        check({tag, "_no_pad"}, 32'(dst[exp_writes]), 32'(8'hEE));
        sb.delete();
    endtask

    localparam string JOKE = "        A joke is a very serious thing.";

    initial begin
        int cyc;
        logic [7:0] exp12;
        init_n  = 1'b0;
        clr_dst = 1'b0;
        bus.req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(bus.ack), 32'(0));
        check("rst_wr_en", 32'(bus.wr_en), 32'(0));
        check("rst_rd_addr", 32'(bus.rd_addr), 32'(64));
        check("rst_wr_addr", 32'(bus.wr_addr), 32'(0));
        check("rst_wr_data", 32'(bus.wr_data), 32'(0));
        check("rst_pat_err", 32'(bus.pat_err), 32'(0));
        check("rst_pat_idx", 32'(bus.pat_idx), 32'(0));
        init_n = 1'b1;
        repeat (2) @(posedge clk);

        // Clean joke: 18 leading spaces stripped, 46 writes.
        stage(7'h60, 7'h01, 10, JOKE, -1, 0);
        launch();
        finish_run("s1", 1'b0, 4'd0, 46);
        check("s1_mem0", 32'(dst[0]), 32'(8'h21));
        check("s1_mem1", 32'(dst[1]), 32'(8'h00));

        // Bit 3 of encrypted byte 30 flipped ('v' -> output index 12).
`ifdef PARITY_FLAG_EN
        exp12 = 8'h80;
`else
        exp12 = 8'h5E;
`endif
        stage(7'h60, 7'h01, 10, JOKE, 30, 3);
        launch();
        finish_run("s2", 1'b0, 4'd0, 46);
        check("s2_mem12", 32'(dst[12]), 32'(exp12));

        // Last pattern, longer preamble.
        stage(7'h7B, 7'h55, 15, "@@@@", -1, 0);
        launch();
        finish_run("s3", 1'b0, 4'd8, 49);
        check("s3_mem3", 32'(dst[3]), 32'(8'h20));
        check("s3_mem4", 32'(dst[4]), 32'(8'h00));

        // Unmatchable preamble: error, no writes.
        for (int i = 0; i < int'(MSG_LEN); i++) src[i] = 8'h01;
        launch();
        finish_run("s4", 1'b1, 4'd0, 0);

        // Reset during the decrypt write phase, then a clean rerun.
        stage(7'h60, 7'h01, 10, JOKE, -1, 0);
        launch();
        cyc = 0;
        do begin
            @(posedge clk);
            #2;
            cyc++;
        end while (wr_seen < 5 && cyc < 300);
        init_n = 1'b0;
        #1;
        check("s5_writes_before_rst", 32'(wr_seen), 32'(5));
        check("s5_rst_ack", 32'(bus.ack), 32'(0));
        check("s5_rst_wr_en", 32'(bus.wr_en), 32'(0));
        check("s5_rst_state", 32'(dut.state), 32'(ST_IDLE));
        check("s5_rst_rd_addr", 32'(bus.rd_addr), 32'(64));
        sb.delete();
        @(negedge clk);
        init_n = 1'b1;
        stage(7'h60, 7'h01, 10, JOKE, -1, 0);
        launch();
        finish_run("s5", 1'b0, 4'd0, 46);
        check("s5_mem0", 32'(dst[0]), 32'(8'h21));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_msg_decoder.md
Name: lfsr_msg_decoder

Overview:
Hardware decrypt engine for the CSE141L message pipeline. It consumes the 64-byte encrypted stream (parity bit in MSB, 7-bit payload) that the encryptor writes at data-memory 64..127. It then recovers the LFSR tap pattern and start state from the all-space preamble, decrypts the stream, and strips the leading spaces. It writes the plaintext (char-0x20) to data-memory 0.., flagging parity-corrupt bytes with bit 7. It sits on the shared data-memory port under the top-level req/ack handshake.

Parameters:
SRC_BASE, 64, first address of encrypted stream
DST_BASE, 0, first address of decrypted output
MSG_LEN, 64, encrypted bytes processed
PRE_MIN, 10, guaranteed minimum preamble bytes used for pattern search
AW, 8, memory address width

Ports:
clk  in  1  clock, rising edge
init_n  in  1  reset; asynchronous, active-low
req  in  1  start request; high holds block idle, high->low launches run
ack  out  1  run complete; held high until req next goes high
rd_addr  out  AW  memory read address
rd_data  in  8  read data, valid one cycle after rd_addr (synchronous RAM)
wr_en  out  1  memory write strobe
wr_addr  out  AW  memory write address
wr_data  out  8  memory write data
pat_err  out  1  no legal tap pattern matched the preamble
pat_idx  out  4  index 0..8 of the matched pattern

Behaviour:
- Reset (init_n=0, any state): state IDLE; ack=0, wr_en=0, rd_addr=SRC_BASE, wr_addr=DST_BASE, wr_data=0, pat_err=0, pat_idx=0. Internal buffers are cleared. Reset mid-run abandons the run; writes already issued stand.
- States: IDLE -> LOAD -> SEARCH -> DECRYPT -> DONE.
- IDLE: leave when req is sampled 0 in a cycle following req=1. On entry, ack=0.
- LOAD: issue PRE_MIN reads, SRC_BASE..SRC_BASE+9, one per cycle, pipelined. Capture ct[i][6:0] into pbuf[0..9]; last capture occurs PRE_MIN+1 cycles after entry.
- SEARCH: one candidate per cycle, k=0..8, taps = LFSR_PTRN[k].
  - A candidate matches when pbuf[i+1] == {pbuf[i][5:0], ^(pbuf[i] & taps)} for all i = 0..8.
  - First match: latch taps, seed = pbuf[0], pat_idx=k; go to DECRYPT.
  - No match after k=8: pat_err=1; go to DONE with no writes.
- DECRYPT: re-read SRC_BASE..SRC_BASE+MSG_LEN-1 at one byte per cycle. The LFSR starts at seed for index 0 and steps once per byte.
  - pt = ct[6:0] ^ lfsr.
  - Parity bad when ^ct[7:0] == 1.
  - Skip phase: bytes with good parity and pt==0 are discarded. The first byte with pt!=0 or bad parity ends the skip phase and is itself written.
  - Write phase: wr_data = bad parity ? 8'h80 : {1'b0, pt}. wr_addr starts at DST_BASE and increments per write.
  - Total writes = MSG_LEN − skipped. No padding is written.
  - Go to DONE after the write for index MSG_LEN-1. If all bytes are spaces, there are zero writes.
- DONE: ack=1, wr_en=0. Hold until req=1, then go to IDLE.
- Latency from launch to ack is at most PRE_MIN+1 + 9 + MSG_LEN+2 cycles.
- req rising during a run is ignored until DONE.

Optional Feature:
PARITY_FLAG_EN
- Defined: parity checking as above; corrupt bytes are written as 8'h80.
- Undefined: parity is ignored; bit 7 is discarded before decryption and output bit 7 is always 0. Skip-phase termination uses pt!=0 only.

Decomposition:
- Package lfsr_pkg holds:
  - LFSR_PTRN[9] = {7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B}
  - state enum
  - function lfsr_next(state, taps)
  - constants PRE_MIN and MSG_LEN
- Sub-module lfsr7: loadable 7-bit LFSR with load/step/taps inputs, shared with the encryptor.

Test Plan:
- taps 0x60, init 0x01, pre_length 10, msg "        A joke is a very serious thing.", no corruption -> pat_idx=0, 18 skipped, mem[0]=0x21 ('A'-0x20), mem[1]=0x00, 46 writes, ack=1, pat_err=0.
- Same run but flip bit 3 of encrypted byte 30 -> mem[12]=0x80; all other 45 outputs correct.
- taps 0x7B, init 0x55, pre_length 15, msg "@@@@" -> pat_idx=8, 15 skipped, mem[0..3]=0x20, mem[4..48]=0x00.
- preamble bytes all 0x01 -> pat_err=1, ack=1, wr_en never asserted.
- init_n pulsed low at DECRYPT write 5 -> ack=0 and state IDLE immediately; a new req high->low completes a correct full run.
- With PARITY_FLAG_EN undefined, the scenario-2 stimulus -> mem[12] = correct char XOR 0x08 with bit 7 = 0.
